// File: rtl/parking_exit_controller.sv
// Exit-gate controller: vehicle detect, exit-code check, barrier control, exit counting.
// Optional wrong-code lockout is compiled in when EXIT_LOCKOUT_EN is defined.
module parking_exit_controller #(
  parameter logic [3:0] EXIT_CODE        = 4'b0101,
  parameter int         CODE_WAIT        = 8,
  parameter int         GATE_OPEN_CYCLES = 16,
  parameter int         MAX_TRIES        = 3,
  parameter int         LOCK_CYCLES      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       exit_sensor,
  input  logic       pass_sensor,
  input  logic       code_valid,
  input  logic [3:0] code,
  input  logic [3:0] parked_count,
  output logic       gate_open,
  output logic       green_led,
  output logic       red_led,
  output logic [6:0] hex_1,
  output logic [6:0] hex_2,
  output logic       exit_pulse,
  output logic [7:0] exits_total
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CODE = 3'd1,
    S_OPEN      = 3'd2,
    S_DENIED    = 3'd3
`ifdef EXIT_LOCKOUT_EN
    , S_LOCKED  = 3'd4
`endif
  } state_t;

  localparam logic [7:0] CODE_LAST = 8'(CODE_WAIT - 1);
  localparam logic [7:0] OPEN_LAST = 8'(GATE_OPEN_CYCLES - 1);
  localparam logic [1:0] TRIES_MAX = 2'(MAX_TRIES);
`ifdef EXIT_LOCKOUT_EN
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYCLES - 1);
`endif

  // Parameter ranges are fixed by the 8-bit timer and the 2-bit tries counter
  if (CODE_WAIT < 1 || CODE_WAIT > 255 || GATE_OPEN_CYCLES < 1 || GATE_OPEN_CYCLES > 255 ||
      MAX_TRIES < 1 || MAX_TRIES > 3 || LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_bad_param
    $error("parking_exit_controller: parameter out of range");
  end

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  tries_q, tries_d, tries_inc;
  logic        gate_open_q, gate_open_d;
  logic        green_q, green_d;
  logic        red_q, red_d;
  logic [6:0]  hex_1_q, hex_1_d;
  logic [6:0]  hex_2_q, hex_2_d;
  logic        exit_pulse_q, exit_pulse_d;
  logic [7:0]  exits_total_q, exits_total_d;
  logic        code_ok, code_bad;

  always_comb begin
    state_d       = state_q;
    tries_d       = tries_q;
    exit_pulse_d  = 1'b0;
    exits_total_d = exits_total_q;
    code_ok       = code_valid && (code == EXIT_CODE);
    code_bad      = code_valid && (code != EXIT_CODE);
    tries_inc     = (tries_q == TRIES_MAX) ? tries_q : tries_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (exit_sensor && (parked_count != 4'd0)) state_d = S_WAIT_CODE;
        else                                       state_d = S_IDLE;
      end
      S_WAIT_CODE, S_DENIED: begin
        if (!exit_sensor) begin
          state_d = S_IDLE;
        end else if (code_ok) begin
          state_d = S_OPEN;
          tries_d = 2'd0;
        end else if (code_bad) begin
          tries_d = tries_inc;
`ifdef EXIT_LOCKOUT_EN
          state_d = (tries_inc >= TRIES_MAX) ? S_LOCKED : S_DENIED;
`else
          state_d = S_DENIED;
`endif
        end else if ((state_q == S_WAIT_CODE) && (timer_q == CODE_LAST)) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_OPEN: begin
        // pass_sensor takes priority over the open-time expiry
        if (pass_sensor) begin
          state_d       = S_IDLE;
          exit_pulse_d  = 1'b1;
          exits_total_d = exits_total_q + 8'd1;
        end else if (timer_q == OPEN_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OPEN;
        end
      end
`ifdef EXIT_LOCKOUT_EN
      S_LOCKED: begin
        if (timer_q == LOCK_LAST) begin
          state_d = S_IDLE;
          tries_d = 2'd0;
        end else begin
          state_d = S_LOCKED;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) timer_d = 8'd0;
    else if (timer_q == 8'hFF) timer_d = timer_q;
    else timer_d = timer_q + 8'd1;

    // Moore outputs decoded from the next state so they line up with the state register
    gate_open_d = 1'b0;
    green_d     = 1'b0;
    red_d       = 1'b0;
    hex_1_d     = 7'b0000000;
    hex_2_d     = 7'b0000000;
    case (state_d)
      S_IDLE: begin
        hex_1_d = 7'b0000000;
      end
      S_WAIT_CODE: begin
        green_d = (state_q != S_WAIT_CODE) ? 1'b1 : ~green_q;
        hex_1_d = 7'b1110011;
        hex_2_d = 7'b1110111;
      end
      S_OPEN: begin
        gate_open_d = 1'b1;
        green_d     = 1'b1;
        hex_1_d     = 7'b0111101;
        hex_2_d     = 7'b1011100;
      end
      S_DENIED: begin
        red_d   = 1'b1;
        hex_1_d = 7'b1111001;
        hex_2_d = 7'b1111001;
      end
`ifdef EXIT_LOCKOUT_EN
      S_LOCKED: begin
        red_d   = (state_q != S_LOCKED) ? 1'b1 : ~red_q;
        hex_1_d = 7'b0111000;
        hex_2_d = 7'b0111111;
      end
`endif
      default: begin
        hex_1_d = 7'b0000000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= 8'd0;
      tries_q       <= 2'd0;
      gate_open_q   <= 1'b0;
      green_q       <= 1'b0;
      red_q         <= 1'b0;
      hex_1_q       <= 7'd0;
      hex_2_q       <= 7'd0;
      exit_pulse_q  <= 1'b0;
      exits_total_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      tries_q       <= tries_d;
      gate_open_q   <= gate_open_d;
      green_q       <= green_d;
      red_q         <= red_d;
      hex_1_q       <= hex_1_d;
      hex_2_q       <= hex_2_d;
      exit_pulse_q  <= exit_pulse_d;
      exits_total_q <= exits_total_d;
    end
  end

  assign gate_open   = gate_open_q;
  assign green_led   = green_q;
  assign red_led     = red_q;
  assign hex_1       = hex_1_q;
  assign hex_2       = hex_2_q;
  assign exit_pulse  = exit_pulse_q;
  assign exits_total = exits_total_q;

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed bench for parking_exit_controller; expectations follow the lockout macro setting.
module tb_parking_exit_controller;

  logic       clk = 1'b0;
  logic       rst, exit_sensor, pass_sensor, code_valid;
  logic [3:0] code, parked_count;
  logic       gate_open, green_led, red_led, exit_pulse;
  logic [6:0] hex_1, hex_2;
  logic [7:0] exits_total;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_total = 0;

  localparam logic [6:0] PA1 = 7'b1110011, PA2 = 7'b1110111;
  localparam logic [6:0] GO1 = 7'b0111101, GO2 = 7'b1011100;
  localparam logic [6:0] EE  = 7'b1111001;
  localparam logic [6:0] LO1 = 7'b0111000, LO2 = 7'b0111111;

  parking_exit_controller dut (
    .clk(clk), .rst(rst), .exit_sensor(exit_sensor), .pass_sensor(pass_sensor),
    .code_valid(code_valid), .code(code), .parked_count(parked_count),
    .gate_open(gate_open), .green_led(green_led), .red_led(red_led),
    .hex_1(hex_1), .hex_2(hex_2), .exit_pulse(exit_pulse), .exits_total(exits_total)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One full exit: arrive, correct code, pass, leave
  task automatic do_exit();
    exit_sensor = 1'b1; tick();
    code = 4'b0101; code_valid = 1'b1; tick();
    code_valid = 1'b0; exit_sensor = 1'b0; pass_sensor = 1'b1; tick();
    pass_sensor = 1'b0; tick();
    exp_total = (exp_total + 1) % 256;
  endtask

  initial begin
    rst = 1'b1; exit_sensor = 1'b0; pass_sensor = 1'b0; code_valid = 1'b0;
    code = 4'd0; parked_count = 4'd3;
    tick(); tick();
    chk("rst_gate", 32'(gate_open), 32'd0);
    chk("rst_green", 32'(green_led), 32'd0);
    chk("rst_red", 32'(red_led), 32'd0);
    chk("rst_hex1", 32'(hex_1), 32'd0);
    chk("rst_hex2", 32'(hex_2), 32'd0);
    chk("rst_pulse", 32'(exit_pulse), 32'd0);
    chk("rst_total", 32'(exits_total), 32'd0);
    rst = 1'b0;

    // Empty lot: phantom exit ignored
    parked_count = 4'd0; exit_sensor = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("empty_gate", 32'(gate_open), 32'd0);
      chk("empty_hex1", 32'(hex_1), 32'd0);
    end
    exit_sensor = 1'b0; parked_count = 4'd3; tick();

    // Normal exit
    exit_sensor = 1'b1; tick();
    chk("wait_hex1", 32'(hex_1), 32'(PA1));
    chk("wait_hex2", 32'(hex_2), 32'(PA2));
    chk("wait_green1", 32'(green_led), 32'd1);
    tick();
    chk("wait_green2", 32'(green_led), 32'd0);
    code = 4'b0101; code_valid = 1'b1; tick();
    code_valid = 1'b0;
    chk("open_gate", 32'(gate_open), 32'd1);
    chk("open_hex1", 32'(hex_1), 32'(GO1));
    chk("open_hex2", 32'(hex_2), 32'(GO2));
    chk("open_green", 32'(green_led), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("open_hold", 32'(gate_open), 32'd1);
      chk("open_nopulse", 32'(exit_pulse), 32'd0);
    end
    pass_sensor = 1'b1; tick();
    pass_sensor = 1'b0; exit_sensor = 1'b0;
    exp_total = 1;
    chk("pass_pulse", 32'(exit_pulse), 32'd1);
    chk("pass_total", 32'(exits_total), 32'd1);
    chk("pass_gate", 32'(gate_open), 32'd0);
    chk("pass_hex1", 32'(hex_1), 32'd0);
    tick();
    chk("pulse_single", 32'(exit_pulse), 32'd0);
    chk("total_hold", 32'(exits_total), 32'd1);

    // Code timeout: IDLE on the 9th edge
    exit_sensor = 1'b1; tick();
    for (int i = 0; i < 7; i++) tick();
    chk("to_edge8_hex", 32'(hex_1), 32'(PA1));
    chk("to_edge8_green", 32'(green_led), 32'd0);
    tick();
    exit_sensor = 1'b0;
    chk("to_edge9_hex", 32'(hex_1), 32'd0);
    tick();

    // Code in the timeout cycle wins
    exit_sensor = 1'b1; tick();
    for (int i = 0; i < 7; i++) tick();
    code = 4'b0101; code_valid = 1'b1; tick();
    code_valid = 1'b0; exit_sensor = 1'b0;
    chk("code_vs_timeout", 32'(gate_open), 32'd1);

    // Gate open 16 cycles without pass
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("gto_open", 32'(gate_open), 32'd1);
      chk("gto_nopulse", 32'(exit_pulse), 32'd0);
    end
    tick();
    chk("gto_closed", 32'(gate_open), 32'd0);
    chk("gto_nopulse_end", 32'(exit_pulse), 32'd0);
    chk("gto_total", 32'(exits_total), 32'(exp_total));
    tick();

    // Pass in the expiry cycle wins
    exit_sensor = 1'b1; tick();
    code_valid = 1'b1; tick();
    code_valid = 1'b0; exit_sensor = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    pass_sensor = 1'b1; tick();
    pass_sensor = 1'b0;
    exp_total++;
    chk("expiry_pass_pulse", 32'(exit_pulse), 32'd1);
    chk("expiry_pass_total", 32'(exits_total), 32'(exp_total));
    tick();

    // Wrong codes
    exit_sensor = 1'b1; tick();
    code = 4'b0011; code_valid = 1'b1; tick();
    chk("den1_hex1", 32'(hex_1), 32'(EE));
    chk("den1_hex2", 32'(hex_2), 32'(EE));
    chk("den1_red", 32'(red_led), 32'd1);
    chk("den1_gate", 32'(gate_open), 32'd0);
    tick();
    chk("den2_hex", 32'(hex_1), 32'(EE));
    tick();
    code_valid = 1'b0;
`ifdef EXIT_LOCKOUT_EN
    chk("lock_hex1", 32'(hex_1), 32'(LO1));
    chk("lock_hex2", 32'(hex_2), 32'(LO2));
    chk("lock_red1", 32'(red_led), 32'd1);
    tick();
    chk("lock_red2", 32'(red_led), 32'd0);
    code = 4'b0101; code_valid = 1'b1; tick();
    code_valid = 1'b0; exit_sensor = 1'b0;
    chk("lock_ignore_gate", 32'(gate_open), 32'd0);
    chk("lock_ignore_hex", 32'(hex_1), 32'(LO1));
    chk("lock_red3", 32'(red_led), 32'd1);
    for (int i = 0; i < 29; i++) tick();
    chk("lock_edge31", 32'(hex_1), 32'(LO1));
    tick();
    chk("lock_release", 32'(hex_1), 32'd0);
    chk("lock_release_red", 32'(red_led), 32'd0);
    // tries cleared: a single wrong code gives DENIED, not LOCKED
    exit_sensor = 1'b1; tick();
    code = 4'b0011; code_valid = 1'b1; tick();
    code_valid = 1'b0;
    chk("tries_cleared", 32'(hex_1), 32'(EE));
    exit_sensor = 1'b0; tick();
    chk("denied_leave", 32'(hex_1), 32'd0);
`else
    chk("nolock_hex", 32'(hex_1), 32'(EE));
    chk("nolock_red", 32'(red_led), 32'd1);
    code = 4'b0101; code_valid = 1'b1; tick();
    code_valid = 1'b0; exit_sensor = 1'b0;
    chk("nolock_open", 32'(gate_open), 32'd1);
    pass_sensor = 1'b1; tick();
    pass_sensor = 1'b0;
    exp_total++;
    chk("nolock_total", 32'(exits_total), 32'(exp_total));
`endif
    tick();

    // Codes outside WAIT_CODE/DENIED are dropped
    code = 4'b0101; code_valid = 1'b1; tick();
    code_valid = 1'b0;
    chk("idle_code_drop", 32'(gate_open), 32'd0);

    // Reset during OPEN with exits_total at 200
    while (exp_total < 200) do_exit();
    chk("total_200", 32'(exits_total), 32'd200);
    exit_sensor = 1'b1; tick();
    code_valid = 1'b1; tick();
    code_valid = 1'b0; exit_sensor = 1'b0;
    chk("pre_rst_gate", 32'(gate_open), 32'd1);
    rst = 1'b1; tick();
    rst = 1'b0;
    exp_total = 0;
    chk("mid_rst_gate", 32'(gate_open), 32'd0);
    chk("mid_rst_total", 32'(exits_total), 32'd0);
    chk("mid_rst_hex1", 32'(hex_1), 32'd0);
    chk("mid_rst_green", 32'(green_led), 32'd0);

    // Wrap 255 -> 0
    while (exp_total < 255) do_exit();
    chk("total_255", 32'(exits_total), 32'd255);
    do_exit();
    chk("total_wrap", 32'(exits_total), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_exit_controller.md
# parking_exit_controller

Exit-gate controller for the car parking system: the outbound counterpart of the entry-gate FSM. It detects a vehicle at the exit lane, validates a 4-bit exit code, opens the barrier, and confirms the departure with a one-cycle pulse that the occupancy counter uses to decrement. It drives the exit-lane LEDs and two 7-segment digits, and keeps a running total of completed exits.

## Interface
Parameters:
- EXIT_CODE, 4'b0101, code that authorises exit
- CODE_WAIT, 8, cycles allowed in WAIT_CODE before timeout (1..255)
- GATE_OPEN_CYCLES, 16, maximum cycles the gate stays open without a pass (1..255)
- MAX_TRIES, 3, wrong codes before lockout (1..3)
- LOCK_CYCLES, 32, lockout duration in cycles (1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- exit_sensor  in  1  vehicle present at exit lane (level)
- pass_sensor  in  1  vehicle has cleared the barrier (level)
- code_valid  in  1  one-cycle strobe, code is valid
- code  in  4  exit code entered by driver
- parked_count  in  4  current occupancy from entry side
- gate_open  out  1  barrier open command
- green_led  out  1  status LED
- red_led  out  1  status LED
- hex_1  out  7  left digit, bit6=g..bit0=a, active-high
- hex_2  out  7  right digit
- exit_pulse  out  1  one-cycle confirmed-exit strobe
- exits_total  out  8  completed exits since reset, wraps 255->0

## Operation
- FSM states: IDLE, WAIT_CODE, OPEN, DENIED, LOCKED. A single 8-bit cycle timer clears on every state change. A 2-bit tries counter tracks wrong codes.
- IDLE:
  - exit_sensor=1 and parked_count!=0 -> WAIT_CODE.
  - exit_sensor=1 and parked_count==0 -> stay in IDLE (phantom exit ignored).
- WAIT_CODE, evaluated in priority order:
  - exit_sensor=0 -> IDLE.
  - code_valid with code==EXIT_CODE -> OPEN.
  - code_valid with a wrong code -> DENIED, tries+1.
  - timer reaches CODE_WAIT-1 -> IDLE.
- OPEN:
  - pass_sensor=1 -> IDLE, with exit_pulse and exits_total+1.
  - timer reaches GATE_OPEN_CYCLES-1 -> IDLE with no pulse.
- DENIED, evaluated in priority order:
  - exit_sensor=0 -> IDLE.
  - correct code -> OPEN.
  - wrong code -> tries+1; stay in DENIED, or go to LOCKED (see Configuration).
- LOCKED: all codes ignored; after LOCK_CYCLES cycles -> IDLE.
- tries clears on entry to OPEN, on entry to IDLE from LOCKED, and on reset.
- Outputs are Moore, registered, and computed from next_state, so they are valid in the same cycle the state register holds that state:
  - IDLE: gate 0, green 0, red 0, hex 0000000/0000000.
  - WAIT_CODE: green toggles every cycle (1 on the first cycle), red 0, "PA" = 1110011/1110111.
  - OPEN: gate 1, green 1, red 0, "Go" = 0111101/1011100.
  - DENIED: red 1, green 0, "EE" = 1111001/1111001.
  - LOCKED: red toggles every cycle (1 on the first cycle), "LO" = 0111000/0111111.

## Timing
- Reset: the state goes to IDLE and every output is 0 (gate_open, LEDs, hex_1, hex_2, exit_pulse, exits_total). Timer and tries are also 0. Reset in mid-operation closes the gate on the next edge, even during OPEN.
- Latency:
  - exit_sensor sampled high in IDLE -> WAIT_CODE outputs after 1 cycle.
  - Correct code_valid -> gate_open=1 after 1 cycle.
  - pass_sensor sampled in OPEN -> exit_pulse=1 for exactly 1 cycle after 1 cycle, in the same cycle the state returns to IDLE and exits_total updates.
- code_valid is sampled only in WAIT_CODE and DENIED; strobes in any other state are dropped.
- If code_valid arrives in the timeout cycle, the code wins over the timeout.
- In OPEN, a pass_sensor in the expiry cycle wins: the pulse is issued.
- exit_sensor is ignored in OPEN and LOCKED.
- exits_total 255 + exit -> 0, with no flag.
- The minimum re-arm time is one cycle in IDLE.

## Configuration
- EXIT_LOCKOUT_EN defined: when the wrong-code count reaches MAX_TRIES in WAIT_CODE or DENIED, the FSM goes to LOCKED.
- EXIT_LOCKOUT_EN undefined:
  - The LOCKED state and its timer compare are not compiled.
  - tries saturates at MAX_TRIES.
  - DENIED persists until a correct code arrives or exit_sensor drops.
  - The LO display is never produced.

## Test plan
- Normal exit: parked_count=3, exit_sensor=1, code=0101 valid on cycle 2, pass_sensor 4 cycles later -> gate_open high 1 cycle after the code, exit_pulse a single cycle, exits_total=1, state IDLE.
- Empty lot: parked_count=0, exit_sensor=1 for 10 cycles -> the FSM stays in IDLE, gate_open=0, hex=0000000.
- Timeouts:
  - No code for CODE_WAIT=8 cycles -> IDLE on the 9th edge.
  - Gate left open 16 cycles with no pass -> gate closes, exit_pulse never asserted, exits_total unchanged.
- Lockout (macro defined, MAX_TRIES=3):
  - Three wrong codes (0011) -> LOCKED with hex 0111000/0111111 and red toggling.
  - A correct code during LOCKED is ignored.
  - After 32 cycles -> IDLE with tries=0.
  - Without the macro, the same stimulus stays in DENIED and a 4th code 0101 opens the gate.
- Reset in OPEN: rst asserted while gate_open=1 -> all outputs 0 on the next edge, and exits_total 200 -> 0. Also preload exits_total=255 and complete one exit -> exits_total=0.
